// File: rtl/pdm_modulator16_pkg.sv
// Shared widths and window constants for the 16-bit pulse-density modulator.
// window_len() maps the latched MODE bit to the window length in cycles.
package pdm_modulator16_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 18;
  localparam int WIN_W    = 17;

  localparam logic [WIN_W-1:0] W_FULL = 17'd65536;
  localparam logic [WIN_W-1:0] W_HALF = 17'd32768;

  function automatic logic [WIN_W-1:0] window_len(input logic mode);
    return mode ? W_HALF : W_FULL;
  endfunction

endpackage

// File: rtl/pdm_modulator16_if.sv
// Sample input handshake: the producer drives din/din_valid, the modulator
// drives din_ready.
interface pdm_modulator16_if;
  import pdm_modulator16_pkg::*;

  logic [SAMPLE_W-1:0] din;
  logic                din_valid;
  logic                din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);

endinterface

// File: rtl/pdm_modulator16_window_timer.sv
// Window timer: cycle index within the window, latched mode and FRAME strobe.
// o_boundary is high on the edge that starts a new window (including the first edge after reset).
module pdm_modulator16_window_timer
  import pdm_modulator16_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_mode,
  output logic                o_boundary,
  output logic                o_mode_nxt,
  output logic [SAMPLE_W-1:0] o_timer,
  output logic                o_frame
);

  logic                r_started;
  logic                r_mode_act;
  logic [SAMPLE_W-1:0] r_timer;
  logic                r_frame;
  logic [WIN_W-1:0]    w_last;

  assign w_last     = window_len(r_mode_act) - 17'd1;
  assign o_boundary = !r_started || ({1'b0, r_timer} == w_last);
  // Mode the datapath must use on this edge: a boundary edge already computes the new window's first bit.
  assign o_mode_nxt = o_boundary ? i_mode : r_mode_act;
  assign o_timer    = r_timer;
  assign o_frame    = r_frame;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_started  <= 1'b0;
      r_mode_act <= 1'b0;
      r_timer    <= '0;
      r_frame    <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_frame   <= o_boundary;
      if (o_boundary) begin
        r_timer    <= '0;
        r_mode_act <= i_mode;
      end else begin
        r_timer <= r_timer + 16'd1;
      end
    end
  end

endmodule

// File: rtl/pdm_modulator16.sv
// First-order delta-sigma modulator: D ones per W-cycle window on o_vmod.
// Samples are held one deep and only take effect at window boundaries.
module pdm_modulator16
  import pdm_modulator16_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  pdm_modulator16_if.slave    s_in,
  input  logic                i_mode,
  output logic                o_vmod,
  output logic                o_frame,
  output logic [SAMPLE_W-1:0] o_timer,
  output logic                o_underrun
);

  function automatic logic [WIN_W-1:0] sat_to_window(input logic [SAMPLE_W-1:0] val,
                                                     input logic [WIN_W-1:0]    win);
    return ({1'b0, val} > win) ? win : {1'b0, val};
  endfunction

  logic                r_hold_full;
  logic [SAMPLE_W-1:0] r_hold;
  logic [SAMPLE_W-1:0] r_active;
  logic [ACC_W-1:0]    r_acc;
  logic                r_vmod;
  logic                r_underrun;

  logic                w_boundary;
  logic                w_mode_nxt;
  logic                w_accept;
  logic [SAMPLE_W-1:0] w_active_nxt;
  logic [WIN_W-1:0]    w_win;
  logic [WIN_W-1:0]    w_d;
  logic [ACC_W-1:0]    w_acc_in;
  logic [ACC_W-1:0]    w_sum;
  logic                w_fire;

  pdm_modulator16_window_timer u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_mode     (i_mode),
    .o_boundary (w_boundary),
    .o_mode_nxt (w_mode_nxt),
    .o_timer    (o_timer),
    .o_frame    (o_frame)
  );

  assign s_in.din_ready = !r_hold_full;
  assign w_accept       = s_in.din_valid && !r_hold_full;

  // Active select: held sample first, then same-edge bypass, else repeat.
  always_comb begin
    w_active_nxt = r_active;
    if (w_boundary) begin
      if (r_hold_full)   w_active_nxt = r_hold;
      else if (w_accept) w_active_nxt = s_in.din;
    end
  end

  // Accumulate stage: clamp to the window, add, subtract W on overflow.
  assign w_win    = window_len(w_mode_nxt);
  assign w_d      = sat_to_window(w_active_nxt, w_win);
  assign w_acc_in = w_boundary ? '0 : r_acc;
  assign w_sum    = w_acc_in + {1'b0, w_d};
  assign w_fire   = (w_sum >= {1'b0, w_win});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold_full <= 1'b0;
      r_active    <= '0;
      r_acc       <= '0;
      r_vmod      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_active   <= w_active_nxt;
      r_vmod     <= w_fire;
      r_acc      <= w_fire ? (w_sum - {1'b0, w_win}) : w_sum;
      r_underrun <= w_boundary && !r_hold_full && !w_accept;
      if (w_boundary)    r_hold_full <= 1'b0;
      else if (w_accept) r_hold_full <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept && !w_boundary) r_hold <= s_in.din;
  end

  assign o_vmod     = r_vmod;
  assign o_underrun = r_underrun;

endmodule

// File: tb/tb_pdm_modulator16.sv
// Directed bench for pdm_modulator16: window ones counts, clamp, bypass,
// underrun, one-deep stall, mid-window MODE change and async reset.
module tb_pdm_modulator16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        vmod;
  logic        frame;
  logic        underrun;
  logic [15:0] timer;
  int          total = 0;
  int          bad   = 0;
  int          ones;
  int          first;

  pdm_modulator16_if bus();

  pdm_modulator16 dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .s_in       (bus),
    .i_mode     (mode),
    .o_vmod     (vmod),
    .o_frame    (frame),
    .o_timer    (timer),
    .o_underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.din       = 16'd0;
    bus.din_valid = 1'b0;
    rst           = 1'b1;
    mode          = 1'b1;
    step();
    step();
    chk("rst_vmod", {31'd0, vmod}, 0);
    chk("rst_frame", {31'd0, frame}, 0);
    chk("rst_timer", {16'd0, timer}, 0);
    chk("rst_underrun", {31'd0, underrun}, 0);
    chk("rst_ready", {31'd0, bus.din_ready}, 1);

    // Window 1: MODE=1, 16384 bypassed on the first edge after release
    bus.din       = 16'd16384;
    bus.din_valid = 1'b1;
    rst           = 1'b0;
    step();
    chk("w1_frame", {31'd0, frame}, 1);
    chk("w1_timer0", {16'd0, timer}, 0);
    chk("w1_underrun", {31'd0, underrun}, 0);
    chk("w1_vmod0", {31'd0, vmod}, 0);
    chk("w1_ready", {31'd0, bus.din_ready}, 1);
    bus.din_valid = 1'b0;
    ones = int'(vmod);
    for (int k = 1; k < 32768; k++) begin
      if (k == 100)   mode = 1'b0;
      if (k == 32000) mode = 1'b1;
      step();
      ones += int'(vmod);
      if (k < 4)  chk("w1_pattern", {31'd0, vmod}, k % 2);
      if (k == 1) chk("w1_frame_low", {31'd0, frame}, 0);
    end
    chk("w1_last_timer", {16'd0, timer}, 32767);
    chk("w1_ones", ones, 16384);

    // Boundary with hold empty: underrun, 16384 repeated
    step();
    chk("w2_frame", {31'd0, frame}, 1);
    chk("w2_wrap_timer", {16'd0, timer}, 0);
    chk("w2_underrun", {31'd0, underrun}, 1);
    chk("w2_vmod0", {31'd0, vmod}, 0);
    ones = int'(vmod);
    for (int k = 1; k < 32768; k++) begin
      if (k == 10) begin
        bus.din       = 16'd40000;
        bus.din_valid = 1'b1;
      end
      step();
      ones += int'(vmod);
      if (k == 1) chk("w2_underrun_pulse", {31'd0, underrun}, 0);
      if (k == 10) begin
        chk("w2_first_accepted", {31'd0, bus.din_ready}, 0);
        bus.din = 16'd0;
      end
      if (k == 500)   chk("w2_stall_mid", {31'd0, bus.din_ready}, 0);
      if (k == 32767) chk("w2_stall_end", {31'd0, bus.din_ready}, 0);
    end
    chk("w2_ones", ones, 16384);

    // Window 3: held 40000 clamped to 32768 -> VMOD high every cycle
    step();
    chk("w3_frame", {31'd0, frame}, 1);
    chk("w3_underrun", {31'd0, underrun}, 0);
    chk("w3_vmod0", {31'd0, vmod}, 1);
    chk("w3_ready_rise", {31'd0, bus.din_ready}, 1);
    step();
    chk("w3_second_accepted", {31'd0, bus.din_ready}, 0);
    chk("w3_vmod1", {31'd0, vmod}, 1);
    bus.din_valid = 1'b0;
    ones = 2;
    for (int k = 2; k <= 1234; k++) begin
      step();
      ones += int'(vmod);
    end
    chk("w3_timer", {16'd0, timer}, 1234);
    chk("w3_clamp_ones", ones, 1235);

    // Asynchronous reset mid-window
    #2 rst = 1'b1;
    #1;
    chk("arst_vmod", {31'd0, vmod}, 0);
    chk("arst_frame", {31'd0, frame}, 0);
    chk("arst_timer", {16'd0, timer}, 0);
    chk("arst_underrun", {31'd0, underrun}, 0);
    chk("arst_ready", {31'd0, bus.din_ready}, 1);
    step();

    // MODE=0, DIN=0 bypassed at restart -> no ones
    mode          = 1'b0;
    bus.din       = 16'd0;
    bus.din_valid = 1'b1;
    rst           = 1'b0;
    step();
    chk("z_frame", {31'd0, frame}, 1);
    chk("z_timer0", {16'd0, timer}, 0);
    chk("z_underrun", {31'd0, underrun}, 0);
    chk("z_ready", {31'd0, bus.din_ready}, 1);
    bus.din_valid = 1'b0;
    ones = int'(vmod);
    for (int k = 1; k < 600; k++) begin
      step();
      ones += int'(vmod);
    end
    chk("z_timer", {16'd0, timer}, 599);
    chk("z_ones", ones, 0);

    // MODE=0, DIN=1000: first one at TIMER=65, 125 ones in 8192 cycles
    rst = 1'b1;
    step();
    bus.din       = 16'd1000;
    bus.din_valid = 1'b1;
    rst           = 1'b0;
    step();
    chk("k_frame", {31'd0, frame}, 1);
    chk("k_vmod0", {31'd0, vmod}, 0);
    chk("k_underrun", {31'd0, underrun}, 0);
    bus.din_valid = 1'b0;
    ones  = int'(vmod);
    first = -1;
    for (int k = 1; k < 8192; k++) begin
      step();
      if (vmod === 1'b1 && first < 0) first = int'(timer);
      ones += int'(vmod);
    end
    chk("k_first_one", first, 65);
    chk("k_ones", ones, 125);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
